// File: rtl/accum_feeder.sv
// accum_feeder
//   Operand queue in front of the accumulator. Buffers 5-bit operation words
//   {sub, operand[3:0]} from a valid/ready producer and issues at most one word
//   per clock onto the accumulator A input. When nothing is issued, A carries
//   the no-op word (add 0) so the accumulator keeps its value.
//
// Parameters
//   DEPTH   queue entries (power of two, >= 2)
//   PTRW    pointer width, log2(DEPTH)
//
// Ports
//   Clk      in   system clock, rising edge
//   Reset    in   asynchronous active-high reset
//   InData   in   [4:0] operation word (bit 4 = subtract, bits 3:0 = operand)
//   InValid  in   producer offers InData
//   InReady  out  queue can accept a word (Level != DEPTH)
//   Hold     in   pause issue; pushes still accepted
//   Flush    in   synchronous discard of all queued words, clears Drop
//   A        out  [4:0] registered word to the accumulator
//   AValid   out  registered; 1 when A carries a queued word
//   Level    out  [PTRW:0] occupancy, 0..DEPTH
//   Drop     out  sticky overflow flag, cleared by Flush or Reset
module accum_feeder #(
   parameter int DEPTH = 4,
   parameter int PTRW  = 2
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic [4:0]      InData,
   input  logic            InValid,
   output logic            InReady,
   input  logic            Hold,
   input  logic            Flush,
   output logic [4:0]      A,
   output logic            AValid,
   output logic [PTRW:0]   Level,
   output logic            Drop
);

   localparam logic [PTRW:0] FULL_LVL = (PTRW+1)'(DEPTH);
   localparam logic [4:0]    NOP_WORD = 5'b00000;

   logic [4:0]      mem [DEPTH];
   logic [PTRW-1:0] wr_ptr;
   logic [PTRW-1:0] rd_ptr;
   logic            push;
   logic            pop;
   logic            overflow;

   // Readiness looks only at the registered level, so a full queue refuses a
   // push even when a pop happens on the same edge.
   assign InReady  = (Level != FULL_LVL);
   assign push     = InValid & InReady & ~Flush;
   assign pop      = (Level != '0) & ~Hold & ~Flush;
   assign overflow = InValid & ~InReady & ~Flush;

   // Storage is data only and carries no reset.
   always_ff @(posedge Clk) begin
      if (push) begin
         mem[wr_ptr] <= InData;
      end
   end

   // Control state and the issue register. Pointers wrap naturally because
   // DEPTH is a power of two. The issue read uses rd_ptr before any write of
   // this edge lands, and a push into an empty queue cannot pop on the same
   // edge because pop requires a nonzero registered Level.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         Level  <= '0;
         Drop   <= 1'b0;
         A      <= NOP_WORD;
         AValid <= 1'b0;
      end else if (Flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         Level  <= '0;
         Drop   <= 1'b0;
         A      <= NOP_WORD;
         AValid <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            A      <= mem[rd_ptr];
            AValid <= 1'b1;
         end else begin
            A      <= NOP_WORD;
            AValid <= 1'b0;
         end
         if (push && !pop) begin
            Level <= Level + 1'b1;
         end else if (pop && !push) begin
            Level <= Level - 1'b1;
         end
         if (overflow) begin
            Drop <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_accum_feeder.sv
// tb_accum_feeder
//   Directed bench for accum_feeder with hand-computed expected values.
//   Inputs change 1 time unit after a rising edge; outputs are sampled there.
module tb_accum_feeder;

   logic       Clk;
   logic       Reset;
   logic [4:0] InData;
   logic       InValid;
   logic       InReady;
   logic       Hold;
   logic       Flush;
   logic [4:0] A;
   logic       AValid;
   logic [2:0] Level;
   logic       Drop;

   int n_chk;
   int n_pass;

   accum_feeder #(.DEPTH(4), .PTRW(2)) dut (
      .Clk     (Clk),
      .Reset   (Reset),
      .InData  (InData),
      .InValid (InValid),
      .InReady (InReady),
      .Hold    (Hold),
      .Flush   (Flush),
      .A       (A),
      .AValid  (AValid),
      .Level   (Level),
      .Drop    (Drop)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk = n_chk + 1;
      if (obs !== exp) begin
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end else begin
         n_pass = n_pass + 1;
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [4:0] ea, input logic ev,
                          input logic [2:0] el);
      chk({tag, ".A"}, 32'(A), 32'(ea));
      chk({tag, ".AValid"}, 32'(AValid), 32'(ev));
      chk({tag, ".Level"}, 32'(Level), 32'(el));
   endtask

   task automatic push_held(input logic [4:0] w);
      Hold    = 1'b1;
      InValid = 1'b1;
      InData  = w;
      tick();
      InValid = 1'b0;
   endtask

   initial begin
      n_chk   = 0;
      n_pass  = 0;
      Reset   = 1'b0;
      InData  = 5'b0;
      InValid = 1'b0;
      Hold    = 1'b0;
      Flush   = 1'b0;

      // Reset takes effect without a clock edge.
      #2 Reset = 1'b1;
      #1;
      chk_out("rst", 5'b00000, 1'b0, 3'd0);
      chk("rst.Drop", 32'(Drop), 32'd0);
      chk("rst.InReady", 32'(InReady), 32'd1);
      tick();
      Reset = 1'b0;

      // Single push: one-cycle lag to A, then back to no-op.
      InData = 5'b00011; InValid = 1'b1;
      tick();
      chk_out("single.e1", 5'b00000, 1'b0, 3'd1);
      InValid = 1'b0;
      tick();
      chk_out("single.e2", 5'b00011, 1'b1, 3'd0);
      tick();
      chk_out("single.e3", 5'b00000, 1'b0, 3'd0);

      // Fill under Hold, then overflow.
      push_held(5'b00001);
      push_held(5'b10010);
      push_held(5'b00100);
      push_held(5'b11000);
      chk_out("fill", 5'b00000, 1'b0, 3'd4);
      chk("fill.InReady", 32'(InReady), 32'd0);
      chk("fill.Drop", 32'(Drop), 32'd0);
      push_held(5'b00111);
      chk("ovf.Drop", 32'(Drop), 32'd1);
      chk("ovf.Level", 32'(Level), 32'd4);
      Hold = 1'b0;
      tick(); chk_out("drain0", 5'b00001, 1'b1, 3'd3);
      tick(); chk_out("drain1", 5'b10010, 1'b1, 3'd2);
      tick(); chk_out("drain2", 5'b00100, 1'b1, 3'd1);
      tick(); chk_out("drain3", 5'b11000, 1'b1, 3'd0);
      tick(); chk_out("drain4", 5'b00000, 1'b0, 3'd0);
      chk("drain.Drop", 32'(Drop), 32'd1);
      Flush = 1'b1;
      tick();
      Flush = 1'b0;
      chk("flush.Drop", 32'(Drop), 32'd0);

      // Streaming 1..10, pointers wrap twice.
      for (int i = 1; i <= 10; i++) begin
         InData  = 5'(i);
         InValid = 1'b1;
         tick();
         if (i == 1) chk_out("stream1", 5'b00000, 1'b0, 3'd1);
         else        chk_out($sformatf("stream%0d", i), 5'(i - 1), 1'b1, 3'd1);
      end
      InValid = 1'b0;
      tick(); chk_out("stream.tail", 5'd10, 1'b1, 3'd0);
      tick(); chk_out("stream.idle", 5'd0, 1'b0, 3'd0);

      // Simultaneous push and pop at Level=2.
      push_held(5'h05);
      push_held(5'h06);
      Hold = 1'b0;
      InValid = 1'b1; InData = 5'h07;
      tick(); chk_out("pp0", 5'h05, 1'b1, 3'd2);
      InData = 5'h08;
      tick(); chk_out("pp1", 5'h06, 1'b1, 3'd2);
      InValid = 1'b0;
      tick(); chk_out("pp2", 5'h07, 1'b1, 3'd1);
      tick(); chk_out("pp3", 5'h08, 1'b1, 3'd0);
      chk("pp.Drop", 32'(Drop), 32'd0);

      // Push into full queue with concurrent pop is refused.
      push_held(5'h11);
      push_held(5'h12);
      push_held(5'h13);
      push_held(5'h14);
      Hold = 1'b0;
      InValid = 1'b1; InData = 5'h1F;
      tick(); chk_out("fullpop", 5'h11, 1'b1, 3'd3);
      chk("fullpop.Drop", 32'(Drop), 32'd1);
      InValid = 1'b0;
      tick(); chk_out("fullpop1", 5'h12, 1'b1, 3'd2);
      tick(); chk_out("fullpop2", 5'h13, 1'b1, 3'd1);
      tick(); chk_out("fullpop3", 5'h14, 1'b1, 3'd0);
      tick(); chk_out("fullpop4", 5'h00, 1'b0, 3'd0);

      // Flush with Level=3 and a word offered.
      push_held(5'h02);
      push_held(5'h03);
      push_held(5'h04);
      chk("preflush.Level", 32'(Level), 32'd3);
      Hold = 1'b0; Flush = 1'b1; InValid = 1'b1; InData = 5'h09;
      tick();
      chk_out("flush", 5'h00, 1'b0, 3'd0);
      chk("flush3.Drop", 32'(Drop), 32'd0);
      chk("flush.InReady", 32'(InReady), 32'd1);
      Flush = 1'b0; InValid = 1'b0;
      tick(); chk_out("postflush", 5'h00, 1'b0, 3'd0);

      // Async reset mid-stream.
      push_held(5'b10101);
      push_held(5'h01);
      push_held(5'h02);
      Hold = 1'b0;
      tick(); chk_out("prereset", 5'b10101, 1'b1, 3'd2);
      #2 Reset = 1'b1;
      #1;
      chk_out("arst", 5'h00, 1'b0, 3'd0);
      chk("arst.InReady", 32'(InReady), 32'd1);
      tick();
      Reset = 1'b0;
      tick(); chk_out("postrst0", 5'h00, 1'b0, 3'd0);
      tick(); chk_out("postrst1", 5'h00, 1'b0, 3'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/accum_feeder.md
# accum_feeder

Operand queue directly upstream of the accumulator. Buffers 5-bit operation words {sub, operand[3:0]} from a producer over a valid/ready handshake and issues one word per clock onto the accumulator's A input. When the queue is empty or held, it drives the no-op word so the accumulator keeps its value.

## Interface
- DEPTH, 4: queue entries; power of two, minimum 2.
- PTRW, 2: pointer width, log2(DEPTH).

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- InData  in  5  operation word; bit 4 = 1 subtract, 0 add; bits 3:0 = operand.
- InValid  in  1  producer offers InData this cycle.
- InReady  out  1  queue can accept a word; combinational, equals (Level != DEPTH).
- Hold  in  1  pauses issue; queue contents keep their values.
- Flush  in  1  synchronous discard of all queued words.
- A  out  5  registered word to the accumulator.
- AValid  out  1  registered; 1 when A carries a queued word, 0 when A is the no-op.
- Level  out  PTRW+1  current occupancy, 0..DEPTH.
- Drop  out  1  sticky; set when InValid=1 while InReady=0.

## Operation
- Push: on an edge with InValid=1 and InReady=1, write InData at wr_ptr, then increment wr_ptr modulo DEPTH.
- Pop/issue: on an edge with Level!=0, Hold=0, Flush=0, load A with the word at rd_ptr, set AValid=1, and increment rd_ptr modulo DEPTH.
- Otherwise, load A with 5'b00000 (add 0, the no-op) and set AValid=0.
- Level: +1 on push-only, −1 on pop-only, unchanged on simultaneous push and pop.
- A full queue does not accept a push, even when a pop happens in the same cycle. InReady depends only on registered Level.
- Empty queue: a word pushed at edge N cannot issue at edge N; there is no bypass path.
- Flush has priority over push and pop. At the edge:
  - wr_ptr, rd_ptr and Level go to 0.
  - Drop goes to 0.
  - A goes to 5'b00000 and AValid goes to 0.
  - Any InData offered in that cycle is discarded without setting Drop.
- Drop: set on any edge where InValid=1, InReady=0 and Flush=0. It stays set until Flush or Reset. The offered word is lost.
- Hold=1: no pop and A = no-op. Pushes continue normally. Hold does not block Flush.
- The block never inspects word contents; the sub/add meaning belongs to the accumulator.

## Timing
- Reset asserted, without waiting for a clock edge:
  - A=5'b00000, AValid=0.
  - Level=0, Drop=0.
  - pointers=0, InReady=1.
  - Queue storage contents are don't-care.
- Reset released: the first push is possible at the next rising edge.
- Latency: a word accepted at edge N appears on A after edge N+1 at the earliest, when the queue was empty and Hold=0.
- Throughput: one word per cycle in, one word per cycle out, sustained without bubbles.
- Order is strictly FIFO. Pointer wrap from DEPTH−1 to 0 is seamless.
- Reset mid-stream: all queued words are discarded and A returns to the no-op immediately.

## Test plan
- Reset then single push: InData=5'b00011 at edge 1 → Level=1 after edge 1; A=5'b00011 with AValid=1 after edge 2; A=5'b00000 with AValid=0 after edge 3; Level=0.
- Fill and overflow: Hold=1, push 5'b00001, 5'b10010, 5'b00100, 5'b11000 → Level=4, InReady=0. Push 5'b00111 → Drop=1 and the word is lost. Release Hold → A shows the four words in order over 4 cycles, then no-op.
- Streaming wrap: continuous pushes of operands 1..10 with Hold=0 → A shows 1..10 in order, one per cycle, after a 1-cycle lag. Level stays at 1 and pointers wrap twice.
- Simultaneous push/pop at Level=2 → Level stays 2 and order is preserved. Push at Level=4 with a concurrent pop → push refused and Drop=1.
- Flush with Level=3 and InValid=1 → after the edge: Level=0, A=5'b00000, AValid=0, Drop=0, and the offered word is discarded.
- Async reset asserted between edges with Level=2 and A=5'b10101 → A=0, AValid=0 and Level=0 immediately; no word issues after release.
